// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl: multi-cycle MIPS main controller (Moore FSM + ALU decoder).
// Optional memory handshake, wait counter and bus-error state under `MIPS_MC_WAIT_EN`.
`default_nettype none

module mips_mc_ctrl #(
  parameter int ALUCTRL_W = 3,
  parameter int MAX_WAIT  = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           op,
  input  logic [5:0]           funct,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 pcen,
  output logic                 irwrite,
  output logic                 regwrite,
  output logic                 memwrite,
  output logic                 memread,
  output logic                 alusrca,
  output logic                 iord,
  output logic                 memtoreg,
  output logic                 regdst,
  output logic [1:0]           alusrcb,
  output logic [1:0]           pcsrc,
  output logic [ALUCTRL_W-1:0] alucontrol,
  output logic                 illegal,
  output logic                 buserr,
  output logic [3:0]           state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEX   = 4'd6,
    S_RTWB   = 4'd7,
    S_BEQEX  = 4'd8,
    S_BNEEX  = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_JEX    = 4'd12,
    S_ERR    = 4'd13
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RT   = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t state_q, state_d;
  logic   rdy;
  logic   timeout;

`ifdef MIPS_MC_WAIT_EN
  logic [7:0] wcnt_q, wcnt_d;
  logic       in_wait_state;

  assign rdy           = mem_ready;
  assign in_wait_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);

  // Timeout fires on the cycle the count of consecutive not-ready cycles hits MAX_WAIT.
  always_comb begin
    timeout = 1'b0;
    wcnt_d  = '0;
    if (in_wait_state && !mem_ready) begin
      wcnt_d  = wcnt_q + 8'd1;
      timeout = (wcnt_d == 8'(MAX_WAIT));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 wcnt_q <= '0;
    else if (state_d != state_q) wcnt_q <= '0;
    else                         wcnt_q <= wcnt_d;
  end
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign rdy              = 1'b1;
  assign timeout          = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (rdy) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RT:        state_d = S_RTEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_BNE:       state_d = S_BNEEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (rdy) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (rdy) state_d = S_FETCH;
      S_RTEX:   state_d = S_RTWB;
      S_RTWB:   state_d = S_FETCH;
      S_BEQEX:  state_d = S_FETCH;
      S_BNEEX:  state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      S_JEX:    state_d = S_FETCH;
      S_ERR:    state_d = S_ERR;
      default:  state_d = S_FETCH;
    endcase
    if (timeout) state_d = S_ERR;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  logic [2:0] alu3;
  logic [2:0] rt_alu;
  logic       pcwrite;
  logic       branch;
  logic       en_pcen, en_irwrite, en_regwrite, en_memwrite, en_memread, en_illegal;

  always_comb begin
    case (funct)
      6'b100000: rt_alu = ALU_ADD;
      6'b100010: rt_alu = ALU_SUB;
      6'b100100: rt_alu = ALU_AND;
      6'b100101: rt_alu = ALU_OR;
      6'b101010: rt_alu = ALU_SLT;
      default:   rt_alu = ALU_ADD;
    endcase
  end

  always_comb begin
    en_irwrite  = 1'b0;
    en_regwrite = 1'b0;
    en_memwrite = 1'b0;
    en_memread  = 1'b0;
    en_illegal  = 1'b0;
    pcwrite     = 1'b0;
    branch      = 1'b0;
    alusrca     = 1'b0;
    iord        = 1'b0;
    memtoreg    = 1'b0;
    regdst      = 1'b0;
    alusrcb     = 2'b00;
    pcsrc       = 2'b00;
    alu3        = 3'b000;
    buserr      = 1'b0;
    case (state_q)
      S_FETCH: begin
        en_memread = 1'b1;
        alusrcb    = 2'b01;
        alu3       = ALU_ADD;
        en_irwrite = rdy;
        pcwrite    = rdy;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        alu3    = ALU_ADD;
        en_illegal = !(op inside {OP_LW, OP_SW, OP_RT, OP_BEQ, OP_BNE, OP_ADDI, OP_J});
      end
      S_MEMADR, S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        alu3    = ALU_ADD;
      end
      S_MEMRD: begin
        iord       = 1'b1;
        en_memread = 1'b1;
      end
      S_MEMWB: begin
        memtoreg    = 1'b1;
        en_regwrite = 1'b1;
      end
      S_MEMWR: begin
        iord        = 1'b1;
        en_memwrite = 1'b1;
      end
      S_RTEX: begin
        alusrca = 1'b1;
        alu3    = rt_alu;
      end
      S_RTWB: begin
        regdst      = 1'b1;
        en_regwrite = 1'b1;
      end
      S_BEQEX, S_BNEEX: begin
        alusrca = 1'b1;
        alu3    = ALU_SUB;
        pcsrc   = 2'b01;
        branch  = (state_q == S_BEQEX) ? zero : !zero;
      end
      S_ADDIWB: en_regwrite = 1'b1;
      S_JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      S_ERR:   buserr = 1'b1;
      default: ;
    endcase
    en_pcen = pcwrite | branch;
  end

  // Enables are held off for the whole reset pulse, not just at the edge.
  always_comb begin
    pcen       = en_pcen     & reset;
    irwrite    = en_irwrite  & reset;
    regwrite   = en_regwrite & reset;
    memwrite   = en_memwrite & reset;
    memread    = en_memread  & reset;
    illegal    = en_illegal  & reset;
    alucontrol = '0;
    alucontrol[2:0] = alu3;
  end

  assign state = state_q;

endmodule

`default_nettype wire
